// File: rtl/sampler_pkg.sv
// Shared definitions for the sampler tag-table logic: FSM state encoding
// and the fixed tag width used by the identity comparator.
package sampler_pkg;

   localparam int SAMPLER_TAG_BW = 20;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

endpackage

// File: rtl/comparator_identity_20b.sv
// 20-bit identity comparator shared by every tag-table slot. The search
// controller time-multiplexes it across slots, one slot per cycle.
module comparator_identity_20b
   import sampler_pkg::*;
(
   input  logic [SAMPLER_TAG_BW-1:0] tag_a,
   input  logic [SAMPLER_TAG_BW-1:0] tag_b,
   output logic                      match
);

   assign match = (tag_a == tag_b);

endmodule

// File: rtl/sampler_tag_search_ctrl.sv
// Sampler tag-table search controller. A request walks every slot through
// the single shared comparator (one slot per cycle), reports hit/index, and
// on a miss with insert enabled writes the tag into the first free slot or,
// when the table is full, into the round-robin victim.
// Optional build macro SAMPLER_SEARCH_EARLY_EXIT_EN: end the scan on the
// first hit instead of always visiting every slot (results are unchanged).
module sampler_tag_search_ctrl
   import sampler_pkg::*;
#(
   parameter int N_ENTRIES = 8
) (
   input  logic                         clock_i,
   input  logic                         resetn_i,
   input  logic                         req_i,
   input  logic [SAMPLER_TAG_BW-1:0]    tag_i,
   input  logic                         insert_i,
   input  logic                         clear_i,
   output logic                         ready_o,
   output logic                         done_o,
   output logic                         hit_o,
   output logic [$clog2(N_ENTRIES)-1:0] index_o,
   output logic                         inserted_o,
   output logic [N_ENTRIES-1:0]         valid_o
);

   localparam int IDX_BW = $clog2(N_ENTRIES);
   localparam int TAG_BW = SAMPLER_TAG_BW;
   localparam logic [IDX_BW-1:0] LAST_IDX = IDX_BW'(N_ENTRIES - 1);

   state_t              state;
   logic [TAG_BW-1:0]   tag_q;
   logic                insert_q;
   logic [IDX_BW-1:0]   ptr;
   logic                hit_q;
   logic [IDX_BW-1:0]   hit_idx;
   logic                free_found;
   logic [IDX_BW-1:0]   free_idx;
   logic [IDX_BW-1:0]   rr_ptr;
   logic [N_ENTRIES-1:0] valid;
   logic [TAG_BW-1:0]   table_q [N_ENTRIES];

   logic                cmp_match;
   logic                cur_match;
   logic                scan_hit;
   logic [IDX_BW-1:0]   scan_idx;
   logic                scan_free_found;
   logic [IDX_BW-1:0]   scan_free_idx;
   logic [IDX_BW-1:0]   victim;
   logic                scan_done;
   logic                tbl_we;
   logic [TAG_BW-1:0]   entry;

   assign entry   = table_q[ptr];
   assign ready_o = (state == ST_IDLE);
   assign valid_o = valid;

   comparator_identity_20b u_cmp (
      .tag_a (tag_q),
      .tag_b (entry),
      .match (cmp_match)
   );

   // Fold the current slot into the running search result; an invalid slot
   // never matches, and the lowest matching/free index is kept.
   always_comb begin
      cur_match       = cmp_match & valid[ptr];
      scan_hit        = hit_q | cur_match;
      scan_idx        = hit_q ? hit_idx : ptr;
      scan_free_found = free_found | ~valid[ptr];
      scan_free_idx   = free_found ? free_idx : ptr;
      victim          = scan_free_found ? scan_free_idx : rr_ptr;
`ifdef SAMPLER_SEARCH_EARLY_EXIT_EN
      scan_done       = (ptr == LAST_IDX) | cur_match;
`else
      scan_done       = (ptr == LAST_IDX);
`endif
      tbl_we          = (state == ST_SEARCH) & ~clear_i & scan_done & ~scan_hit & insert_q;
   end

   // Tag storage is not reset; only the valid bits qualify its contents.
   always_ff @(posedge clock_i) begin
      if (tbl_we) begin
         table_q[victim] <= tag_q;
      end
   end

   // Controller FSM with registered result outputs; clear overrides every state.
   always_ff @(posedge clock_i or negedge resetn_i) begin
      if (!resetn_i) begin
         state      <= ST_IDLE;
         tag_q      <= '0;
         insert_q   <= 1'b0;
         ptr        <= '0;
         hit_q      <= 1'b0;
         hit_idx    <= '0;
         free_found <= 1'b0;
         free_idx   <= '0;
         rr_ptr     <= '0;
         valid      <= '0;
         done_o     <= 1'b0;
         hit_o      <= 1'b0;
         index_o    <= '0;
         inserted_o <= 1'b0;
      end else if (clear_i) begin
         valid  <= '0;
         state  <= ST_IDLE;
         done_o <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               done_o <= 1'b0;
               if (req_i) begin
                  tag_q      <= tag_i;
                  insert_q   <= insert_i;
                  ptr        <= '0;
                  hit_q      <= 1'b0;
                  hit_idx    <= '0;
                  free_found <= 1'b0;
                  free_idx   <= '0;
                  state      <= ST_SEARCH;
               end
            end
            ST_SEARCH: begin
               hit_q      <= scan_hit;
               hit_idx    <= scan_idx;
               free_found <= scan_free_found;
               free_idx   <= scan_free_idx;
               if (scan_done) begin
                  state  <= ST_RESP;
                  done_o <= 1'b1;
                  hit_o  <= scan_hit;
                  if (scan_hit) begin
                     index_o    <= scan_idx;
                     inserted_o <= 1'b0;
                  end else if (insert_q) begin
                     index_o       <= victim;
                     inserted_o    <= 1'b1;
                     valid[victim] <= 1'b1;
                     if (!scan_free_found) begin
                        rr_ptr <= rr_ptr + 1'b1;
                     end
                  end else begin
                     index_o    <= '0;
                     inserted_o <= 1'b0;
                  end
               end else begin
                  ptr <= ptr + 1'b1;
               end
            end
            ST_RESP: begin
               done_o <= 1'b0;
               state  <= ST_IDLE;
            end
            default: begin
               done_o <= 1'b0;
               state  <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
